// File: rtl/hash_feed_buffer.sv
// hash_feed_buffer: buffers HASH-port words written by the multiplier core
// and streams each completed block to the hash core over valid/ready.
module hash_feed_buffer #(
  parameter int DEPTH    = 32,
  parameter int ADDR_LSB = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen_HASH,
  input  logic [31:0]                addr_HASH,
  input  logic [63:0]                bram_wdata_HASH,
  output logic [63:0]                bram_data_HASH,
  output logic                       HASH_ready,
  input  logic                       blk_flush,
  output logic [63:0]                hash_tdata,
  output logic                       hash_tvalid,
  input  logic                       hash_tready,
  output logic                       hash_tlast,
  output logic [$clog2(DEPTH):0]     blk_words,
  output logic                       err_overrun
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [63:0]       mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     hi_q, hi_d;
  logic              any_q, any_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     ptr_q, ptr_d;
  logic [1:0][63:0]  dat_q, dat_d;
  logic [1:0]        lst_q, lst_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [63:0]       rdata_q, rdata_d;

  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [1:0]        occ;
  logic              fill, wr_en, trig, pop, push;
  logic              unused_addr;

  assign wr_idx      = addr_HASH[ADDR_LSB +: IW];
  assign rd_idx      = ptr_q[IW-1:0];
  assign unused_addr = ^addr_HASH;

  assign fill  = (state_q == S_FILL);
  assign wr_en = wen_HASH && fill;
  assign pop   = (cnt_q != 2'd0) && hash_tready;
  // A slot frees up in the same cycle the head is popped.
  assign push  = !fill && (ptr_q < len_q)
               && ((cnt_q != 2'd2) || pop);
  assign trig  = (wr_en && (wr_idx == IW'(DEPTH - 1)))
              || (blk_flush && fill && (any_q || wr_en));
  assign occ   = cnt_q - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    any_d   = any_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    dat_d   = dat_q;
    lst_d   = lst_q;
    err_d   = err_q;
    rdata_d = mem_q[wr_idx];
    if (wr_en && (wr_idx > hi_q)) hi_d = wr_idx;
    if (wr_en) any_d = 1'b1;
    if (!fill && wen_HASH) err_d = 1'b1;
    if (trig) begin
      state_d = S_DRAIN;
      len_d   = LW'(hi_d) + LW'(1);
      ptr_d   = '0;
    end
    if (pop) begin
      dat_d[0] = dat_q[1];
      lst_d[0] = lst_q[1];
      lst_d[1] = 1'b0;
    end
    if (push) begin
      dat_d[occ[0]] = mem_q[rd_idx];
      lst_d[occ[0]] = (ptr_q == len_q - LW'(1));
      ptr_d         = ptr_q + LW'(1);
    end
    cnt_d = occ + {1'b0, push};
    if (pop && lst_q[0]) begin
      state_d = S_FILL;
      hi_d    = '0;
      any_d   = 1'b0;
      len_d   = '0;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= bram_wdata_HASH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      hi_q    <= '0;
      any_q   <= 1'b0;
      len_q   <= '0;
      ptr_q   <= '0;
      dat_q   <= '0;
      lst_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      any_q   <= any_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      dat_q   <= dat_d;
      lst_q   <= lst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bram_data_HASH = rdata_q;
  assign HASH_ready     = fill;
  assign hash_tvalid    = (cnt_q != 2'd0);
  assign hash_tdata     = dat_q[0];
  assign hash_tlast     = lst_q[0] && hash_tvalid;
  assign blk_words      = len_q;
  assign err_overrun    = err_q;

endmodule

// File: tb/tb_hash_feed_buffer.sv
// tb_hash_feed_buffer: randomized scenarios checked against a RAM-image
// model of the buffer; each task checks its own scenario inline.
module tb_hash_feed_buffer;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen_HASH;
  logic [31:0] addr_HASH;
  logic [63:0] bram_wdata_HASH;
  logic [63:0] bram_data_HASH;
  logic        HASH_ready;
  logic        blk_flush;
  logic [63:0] hash_tdata;
  logic        hash_tvalid;
  logic        hash_tready;
  logic        hash_tlast;
  logic [5:0]  blk_words;
  logic        err_overrun;

  hash_feed_buffer #(.DEPTH(D), .ADDR_LSB(0)) dut (
    .clk(clk), .rst(rst),
    .wen_HASH(wen_HASH), .addr_HASH(addr_HASH),
    .bram_wdata_HASH(bram_wdata_HASH),
    .bram_data_HASH(bram_data_HASH),
    .HASH_ready(HASH_ready), .blk_flush(blk_flush),
    .hash_tdata(hash_tdata), .hash_tvalid(hash_tvalid),
    .hash_tready(hash_tready), .hash_tlast(hash_tlast),
    .blk_words(blk_words), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: image of the RAM plus the highest index written in this block.
  logic [63:0] model_mem [D];
  int          model_hi = -1;
  logic [63:0] exp_q [$];
  logic [63:0] got_d [$];
  bit          got_l [$];
  int          ncyc;
  int          unstable;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [63:0] d);
    wen_HASH = 1'b1;
    addr_HASH = 32'(idx);
    bram_wdata_HASH = d;
    step();
    wen_HASH = 1'b0;
    model_mem[idx] = d;
    if (idx > model_hi) model_hi = idx;
  endtask

  task automatic flush();
    blk_flush = 1'b1;
    step();
    blk_flush = 1'b0;
  endtask

  task automatic snap();
    exp_q.delete();
    for (int k = 0; k <= model_hi; k++) exp_q.push_back(model_mem[k]);
    model_hi = -1;
  endtask

  task automatic collect(input bit bp);
    bit done;
    bit prev_stall;
    logic [63:0] pd;
    logic pl;
    got_d.delete();
    got_l.delete();
    ncyc = 0;
    unstable = 0;
    done = 1'b0;
    prev_stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      hash_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (hash_tvalid !== 1'b1 || hash_tdata !== pd
                         || hash_tlast !== pl))
        unstable++;
      ncyc++;
      if (hash_tvalid === 1'b1 && hash_tready) begin
        got_d.push_back(hash_tdata);
        got_l.push_back(hash_tlast === 1'b1);
        if (hash_tlast === 1'b1) done = 1'b1;
      end
      prev_stall = (hash_tvalid === 1'b1) && !hash_tready;
      pd = hash_tdata;
      pl = hash_tlast;
      step();
    end
    hash_tready = 1'b0;
  endtask

  function automatic int block_diff();
    int d;
    d = 0;
    if (got_d.size() != exp_q.size()) return 1000 + got_d.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_d[i] !== exp_q[i]) d++;
      if (got_l[i] != (i == exp_q.size() - 1)) d++;
    end
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({HASH_ready, hash_tvalid, hash_tlast, err_overrun} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 1000",
               {HASH_ready, hash_tvalid, hash_tlast, err_overrun});
    end
    n_cmp++;
    if (hash_tdata !== 64'd0 || bram_data_HASH !== 64'd0 || blk_words !== 6'd0) begin
      n_err++;
      $display("FAIL reset_data: got tdata %0h rdata %0h words %0d expected 0",
               hash_tdata, bram_data_HASH, blk_words);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_block();
    for (int i = 0; i < D - 1; i++) wr(i, 64'hA5A5_0000_0000_0000 + 64'(i));
    n_cmp++;
    if (HASH_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_ready_before: got %b expected 1", HASH_ready);
    end
    wr(D - 1, 64'hA5A5_0000_0000_0000 + 64'(D - 1));
    n_cmp++;
    if (HASH_ready !== 1'b0 || blk_words !== 6'd32 || hash_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL full_entry: got ready %b words %0d valid %b expected 0 32 0",
               HASH_ready, blk_words, hash_tvalid);
    end
    snap();
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL full_beats: got %0d beats diff %0d expected 32 diff 0",
               got_d.size(), block_diff());
    end
    n_cmp++;
    if (ncyc !== D + 1) begin
      n_err++;
      $display("FAIL full_latency: got %0d cycles expected %0d", ncyc, D + 1);
    end
    n_cmp++;
    if (HASH_ready !== 1'b1 || blk_words !== 6'd0) begin
      n_err++;
      $display("FAIL full_exit: got ready %b words %0d expected 1 0",
               HASH_ready, blk_words);
    end
  endtask

  task automatic test_partial_flush();
    for (int i = 0; i < 5; i++) wr(i, {$urandom, $urandom});
    flush();
    n_cmp++;
    if (blk_words !== 6'd5 || HASH_ready !== 1'b0) begin
      n_err++;
      $display("FAIL partial_words: got %0d ready %b expected 5 0",
               blk_words, HASH_ready);
    end
    snap();
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL partial_beats: got %0d beats diff %0d expected 5 diff 0",
               got_d.size(), block_diff());
    end
  endtask

  task automatic test_empty_flush();
    flush();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (HASH_ready !== 1'b1 || hash_tvalid !== 1'b0 || blk_words !== 6'd0) begin
        n_err++;
        $display("FAIL empty_flush: got ready %b valid %b words %0d expected 1 0 0",
                 HASH_ready, hash_tvalid, blk_words);
      end
      step();
    end
  endtask

  task automatic test_flush_with_write();
    logic [63:0] d;
    wr(0, {$urandom, $urandom});
    wr(1, {$urandom, $urandom});
    d = {$urandom, $urandom};
    blk_flush = 1'b1;
    wr(2, d);
    blk_flush = 1'b0;
    n_cmp++;
    if (blk_words !== 6'd3) begin
      n_err++;
      $display("FAIL flush_same_cycle: got %0d words expected 3", blk_words);
    end
    snap();
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL flush_same_beats: got %0d beats diff %0d expected 3 diff 0",
               got_d.size(), block_diff());
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < D; i++) wr(i, {$urandom, $urandom});
    snap();
    collect(1'b1);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL bp_beats: got %0d beats diff %0d expected 32 diff 0",
               got_d.size(), block_diff());
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d unstable stalls expected 0", unstable);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) wr(i, {$urandom, $urandom});
    flush();
    snap();
    wen_HASH = 1'b1;
    addr_HASH = 32'd3;
    bram_wdata_HASH = 64'hDEAD;
    step();
    wen_HASH = 1'b0;
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_flag: got %b expected 1", err_overrun);
    end
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL overrun_beats: got %0d beats diff %0d expected 8 diff 0",
               got_d.size(), block_diff());
    end
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b expected 1", err_overrun);
    end
    d = {$urandom, $urandom};
    blk_flush = 1'b1;
    wr(0, d);
    blk_flush = 1'b0;
    n_cmp++;
    if (HASH_ready !== 1'b0 || blk_words !== 6'd1) begin
      n_err++;
      $display("FAIL exit_write: got ready %b words %0d expected 0 1",
               HASH_ready, blk_words);
    end
    snap();
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL exit_write_beats: got %0d beats diff %0d expected 1 diff 0",
               got_d.size(), block_diff());
    end
  endtask

  task automatic test_read_port();
    wr(7, 64'h1234);
    addr_HASH = 32'd7;
    step();
    n_cmp++;
    if (bram_data_HASH !== 64'h1234) begin
      n_err++;
      $display("FAIL read_port: got %0h expected 1234", bram_data_HASH);
    end
    wr(7, 64'h5678);
    n_cmp++;
    if (bram_data_HASH !== 64'h1234) begin
      n_err++;
      $display("FAIL read_old: got %0h expected 1234", bram_data_HASH);
    end
    step();
    n_cmp++;
    if (bram_data_HASH !== 64'h5678) begin
      n_err++;
      $display("FAIL read_new: got %0h expected 5678", bram_data_HASH);
    end
    flush();
    snap();
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL read_block: got %0d beats diff %0d expected 8 diff 0",
               got_d.size(), block_diff());
    end
  endtask

  task automatic test_reset_mid_drain();
    int hs;
    for (int i = 0; i < D; i++) wr(i, {$urandom, $urandom});
    model_hi = -1;
    hash_tready = 1'b1;
    hs = 0;
    for (int c = 0; c < 100 && hs < 11; c++) begin
      if (hash_tvalid === 1'b1) hs++;
      step();
    end
    hash_tready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (hash_tvalid !== 1'b0 || HASH_ready !== 1'b1 || blk_words !== 6'd0
        || err_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got valid %b ready %b words %0d err %b expected 0 1 0 0",
               hash_tvalid, HASH_ready, blk_words, err_overrun);
    end
    wr(0, {$urandom, $urandom});
    wr(1, {$urandom, $urandom});
    flush();
    snap();
    collect(1'b0);
    n_cmp++;
    if (block_diff() !== 0) begin
      n_err++;
      $display("FAIL post_reset_beats: got %0d beats diff %0d expected 2 diff 0",
               got_d.size(), block_diff());
    end
  endtask

  initial begin
    rst = 1'b1;
    wen_HASH = 1'b0;
    addr_HASH = '0;
    bram_wdata_HASH = '0;
    blk_flush = 1'b0;
    hash_tready = 1'b0;
    test_reset();
    test_full_block();
    test_partial_flush();
    test_empty_flush();
    test_flush_with_write();
    test_backpressure();
    test_overrun();
    test_read_port();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
